// File: rtl/redmule_tcdm_responder.sv
// Word-interleaved multi-bank TCDM slave: per-bank round-robin arbitration, same-cycle grant, 1-cycle response.
// Optional macro REDMULE_TCDM_RESP_STALL_EN adds LFSR-driven random bank stalls.
module redmule_tcdm_responder #(
    parameter int unsigned MP         = 4,
    parameter int unsigned NB         = 8,
    parameter int unsigned BANK_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR  = 32'h0,
    parameter logic [15:0] STALL_SEED = 16'hACE1
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic [MP-1:0]       tcdm_req,
    output logic [MP-1:0]       tcdm_gnt,
    input  logic [MP-1:0][31:0] tcdm_add,
    input  logic [MP-1:0]       tcdm_wen,
    input  logic [MP-1:0][3:0]  tcdm_be,
    input  logic [MP-1:0][31:0] tcdm_data,
    output logic [MP-1:0][31:0] tcdm_r_data,
    output logic [MP-1:0]       tcdm_r_valid
);
    localparam int unsigned NBW   = $clog2(NB);
    localparam int unsigned PW    = (MP > 1) ? $clog2(MP) : 1;
    localparam int unsigned AW    = NBW + $clog2(BANK_WORDS);
    localparam int unsigned DEPTH = NB * BANK_WORDS;

    logic [MP-1:0][31:0]    off;
    logic [MP-1:0][AW-1:0]  port_flat;
    logic [MP-1:0][NBW-1:0] port_bank;
    logic [NB-1:0][PW-1:0]  rr_ptr_q;
    logic [NB-1:0][PW-1:0]  bank_win;
    logic [NB-1:0]          bank_gnt;
    logic [NB-1:0]          stall;
    logic [MP-1:0]          r_valid_q;
    logic [MP-1:0][31:0]    r_data_q;
    logic [31:0]            mem_q [DEPTH];
    logic                   unused_addr_bits;

    // The flat word index {row, bank} is simply the low AW bits of the word offset,
    // which also gives the silent wrap for out-of-range addresses.
    always_comb begin
        for (int p = 0; p < MP; p++) begin
            off[p]       = tcdm_add[p] - BASE_ADDR;
            port_flat[p] = off[p][AW+1:2];
            port_bank[p] = off[p][NBW+1:2];
        end
    end
    assign unused_addr_bits = ^off;

`ifdef REDMULE_TCDM_RESP_STALL_EN
    logic [15:0] lfsr_q;
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) lfsr_q <= STALL_SEED;
        else         lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    end
    assign stall = lfsr_q[NB-1:0];
`else
    assign stall = '0;
`endif

    always_comb begin
        int p;
        logic [PW-1:0] p_sel;
        p        = 0;
        p_sel    = '0;
        bank_gnt = '0;
        bank_win = '0;
        for (int b = 0; b < NB; b++) begin
            for (int o = 0; o < MP; o++) begin
                p = int'(rr_ptr_q[b]) + o;
                if (p >= int'(MP)) p = p - int'(MP);
                p_sel = PW'(p);
                if (!bank_gnt[b] && tcdm_req[p_sel] && (port_bank[p_sel] == NBW'(b))) begin
                    bank_gnt[b] = 1'b1;
                    bank_win[b] = p_sel;
                end
            end
            bank_gnt[b] = bank_gnt[b] & ~stall[b] & rst_ni;
        end
    end

    always_comb begin
        for (int p = 0; p < MP; p++) begin
            tcdm_gnt[p] = tcdm_req[p] & bank_gnt[port_bank[p]] & (bank_win[port_bank[p]] == PW'(p));
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_ptr_q  <= '0;
            r_valid_q <= '0;
            r_data_q  <= '0;
        end else begin
            for (int b = 0; b < NB; b++) begin
                if (bank_gnt[b]) begin
                    rr_ptr_q[b] <= (bank_win[b] == PW'(MP - 1)) ? '0 : bank_win[b] + PW'(1);
                end
            end
            r_valid_q <= tcdm_gnt;
            for (int p = 0; p < MP; p++) begin
                r_data_q[p] <= (tcdm_gnt[p] && tcdm_wen[p]) ? mem_q[port_flat[p]] : 32'h0;
            end
        end
    end

    // At most one grant per bank, so granted writes never collide on a word.
    always_ff @(posedge clk_i) begin
        for (int p = 0; p < MP; p++) begin
            if (tcdm_gnt[p] && !tcdm_wen[p]) begin
                for (int k = 0; k < 4; k++) begin
                    if (tcdm_be[p][k]) mem_q[port_flat[p]][8*k +: 8] <= tcdm_data[p][8*k +: 8];
                end
            end
        end
    end

    assign tcdm_r_valid = r_valid_q;
    assign tcdm_r_data  = r_data_q;
endmodule
